// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with a one-byte valid/ready holding register.
// Ports: clk, rstn (async active-low), uart_rx (serial in, idle high),
//   data_out/data_valid/data_ready (holding register handshake),
//   framing_error and overrun (one-cycle pulses), busy (FSM not idle).
// Define UART_RX_PARITY_EN for 8E1 reception with parity checking.
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_BITS = 12
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);
  localparam logic [CNT_BITS-1:0] HALF = CNT_BITS'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif
  state_t state;
  logic s1, s2, done, par_err;
  logic [CNT_BITS-1:0] bit_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  wire rx = s2;
  wire tick = bit_cnt == '0;
  assign busy = state != IDLE;
`ifndef UART_RX_PARITY_EN
  assign par_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      {s2, s1} <= 2'b11;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      done <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err <= 1'b0;
`endif
      data_out <= '0;
      data_valid <= 1'b0;
      framing_error <= 1'b0;
      overrun <= 1'b0;
    end else begin
      {s2, s1} <= {s1, uart_rx};
      framing_error <= 1'b0;
      done <= 1'b0;
      if (!tick) bit_cnt <= bit_cnt - CNT_BITS'(1);
      case (state)
        IDLE: if (!rx) begin
          bit_cnt <= HALF;
          state <= START;
        end
        START: if (tick) begin
          if (!rx) begin
            bit_cnt <= FULL;
            shreg <= '0;
            bit_idx <= '0;
            state <= DATA;
          end else state <= IDLE;
        end
        DATA: if (tick) begin
          shreg <= {rx, shreg[7:1]};
          bit_cnt <= FULL;
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          par_err <= rx ^ (^shreg);
          bit_cnt <= FULL;
          state <= STOP;
        end
`endif
        STOP: if (tick) begin
          done <= rx && !par_err;
          framing_error <= !rx || par_err;
          state <= rx ? IDLE : BRK;
        end
        BRK: if (rx) state <= IDLE;
        default: state <= IDLE;
      endcase
      // shreg is untouched until the next START tick, so it still holds the byte here
      overrun <= done && data_valid && !data_ready;
      if (done && (!data_valid || data_ready)) begin
        data_out <= shreg;
        data_valid <= 1'b1;
      end else if (data_ready) data_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed bench for uart_rx_buffered at CLKS_PER_BIT=8.
module tb_uart_rx_buffered;
  logic clk = 0, rstn = 0, uart_rx = 1, data_ready = 1;
  logic [7:0] data_out;
  logic data_valid, framing_error, overrun, busy;
  int checks = 0, failures = 0;
  int cyc = 0, last_start = 0, rise_cyc = 0, ov_cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, fe0, ov0;
  logic dv_q = 0;
  logic [7:0] q[$];
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 87;
`else
  localparam int LAT = 79;
`endif

  uart_rx_buffered #(.CLKS_PER_BIT(8), .CNT_BITS(12)) dut (
    .clk(clk), .rstn(rstn), .uart_rx(uart_rx), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready),
    .framing_error(framing_error), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid && data_ready) q.push_back(data_out);
    if (framing_error) fe_cnt++;
    if (overrun) begin ov_cnt++; ov_cyc = cyc; end
    if (framing_error && overrun) both_cnt++;
    if (data_valid && !dv_q) rise_cyc = cyc;
    dv_q = data_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, optional parity, stop; the stop bit is
  // held 7 cycles so a following send yields zero idle gap.
  task automatic send(input logic [7:0] b, input logic stop, input logic par);
    @(posedge clk);
    #1 uart_rx = 0;
    last_start = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(posedge clk);
      #1 uart_rx = b[i];
    end
`ifdef UART_RX_PARITY_EN
    repeat (8) @(posedge clk);
    #1 uart_rx = par;
`else
    if (par === 1'bx) uart_rx = 1'bx;
`endif
    repeat (8) @(posedge clk);
    #1 uart_rx = stop;
    repeat (7) @(posedge clk);
  endtask

  initial begin
    idle(3);
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_fe", framing_error, 0);
    check("rst_ov", overrun, 0);
    check("rst_busy", busy, 0);
    rstn = 1;
    idle(5);
    // single byte with latency
    send(8'hA5, 1, 0);
    idle(20);
    check("t1_count", q.size(), 1);
    check("t1_data", q.size() > 0 ? q[0] : 8'h00, 8'hA5);
    check("t1_latency", rise_cyc - last_start - 1, LAT);
    check("t1_fe", fe_cnt, 0);
    check("t1_ov", ov_cnt, 0);
    check("t1_valid_cleared", data_valid, 0);
    // back-to-back frames
    q.delete();
    send(8'h00, 1, 0);
    send(8'hFF, 1, 0);
    send(8'h55, 1, 0);
    idle(20);
    check("t2_count", q.size(), 3);
    check("t2_d0", q.size() > 0 ? q[0] : 8'hxx, 8'h00);
    check("t2_d1", q.size() > 1 ? q[1] : 8'hxx, 8'hFF);
    check("t2_d2", q.size() > 2 ? q[2] : 8'hxx, 8'h55);
    check("t2_fe", fe_cnt, 0);
    // overrun
    q.delete();
    data_ready = 0;
    send(8'h12, 1, 0);
    send(8'h34, 1, 1);
    idle(20);
    check("t3_ov_count", ov_cnt, 1);
    check("t3_ov_time", ov_cyc - last_start - 1, LAT);
    check("t3_data_held", data_out, 8'h12);
    check("t3_valid_held", data_valid, 1);
    check("t3_no_xfer", q.size(), 0);
    data_ready = 1;
    idle(3);
    check("t3_xfer_count", q.size(), 1);
    check("t3_xfer_data", q.size() > 0 ? q[0] : 8'h00, 8'h12);
    check("t3_valid_clr", data_valid, 0);
    // framing error then break
    q.delete();
    fe0 = fe_cnt;
    send(8'h3C, 0, 0);
    #1 uart_rx = 0;
    idle(40);
    check("t4_busy_brk", busy, 1);
    uart_rx = 1;
    idle(20);
    check("t4_fe_once", fe_cnt - fe0, 1);
    check("t4_no_data", q.size(), 0);
    check("t4_idle", busy, 0);
    send(8'h81, 1, 0);
    idle(20);
    check("t4_next_count", q.size(), 1);
    check("t4_next_data", q.size() > 0 ? q[0] : 8'h00, 8'h81);
    // glitch
    q.delete();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    @(posedge clk);
    #1 uart_rx = 0;
    idle(3);
    uart_rx = 1;
    idle(20);
    check("t5_glitch_busy", busy, 0);
    check("t5_glitch_nodata", q.size() + data_valid, 0);
    check("t5_glitch_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    // reset mid-DATA while the holding register is full
    data_ready = 0;
    send(8'h5A, 1, 0);
    idle(10);
    check("t5_pre_valid", data_valid, 1);
    @(posedge clk);
    #1 uart_rx = 0;
    idle(30);
    check("t5_pre_busy", busy, 1);
    rstn = 0;
    #1;
    check("t5_rst_valid", data_valid, 0);
    check("t5_rst_data", data_out, 0);
    check("t5_rst_busy", busy, 0);
    uart_rx = 1;
    idle(3);
    rstn = 1;
    data_ready = 1;
    idle(5);
    send(8'h7E, 1, 0);
    idle(20);
    check("t5_after_count", q.size(), 1);
    check("t5_after_data", q.size() > 0 ? q[0] : 8'h00, 8'h7E);
`ifdef UART_RX_PARITY_EN
    q.delete();
    fe0 = fe_cnt;
    send(8'hA5, 1, 0);
    idle(20);
    check("t6_good_count", q.size(), 1);
    check("t6_good_data", q.size() > 0 ? q[0] : 8'h00, 8'hA5);
    send(8'hA5, 1, 1);
    idle(20);
    check("t6_bad_fe", fe_cnt - fe0, 1);
    check("t6_bad_nodata", q.size(), 1);
`endif
    check("never_both_flags", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
